// File: rtl/mc_pkg.sv
// Shared encodings and the control-word payload for the multicycle MIPS-subset controller.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] FUNCT_SRA = 6'h03;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath select and enable driven by the controller.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       apply_shift;
        logic [1:0] alu_alt_ctrl;
        logic       reg_dst_rtrd;
        logic       mem_to_reg;
        logic       enable_wreg;
    } ctrl_t;

    // Shift R-types route reg B to ALU input A and shamt to input B.
    function automatic logic is_shift(input logic [FUNCT_W-1:0] funct);
        return (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);
    endfunction

endpackage

// File: rtl/mc_out_dec.sv
// State-to-control-word decoder; pc_en/ir_write are qualified by zero/ready.
module mc_out_dec
    import mc_pkg::*;
(
    input  state_t             state,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    // Decode the control word; unlisted fields and unreached encodings stay 0.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg  = 1'b1;
                ctrl.enable_wreg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_REGB;
                ctrl.alu_alt_ctrl = ALU_FUNCT;
                ctrl.apply_shift  = is_shift(funct);
            end
            RTYPEWB: begin
                ctrl.reg_dst_rtrd = 1'b1;
                ctrl.enable_wreg  = 1'b1;
            end
            BEQEX, BNEEX: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_REGB;
                ctrl.alu_alt_ctrl = ALU_SUB;
                ctrl.pc_src       = PCSRC_ALUOUT;
                ctrl.pc_en        = (state == BEQEX) ? zero : ~zero;
            end
            ADDIWB: begin
                ctrl.enable_wreg = 1'b1;
            end
            JEX: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: state register, next-state logic and reset gating of enables.
module mc_controller
    import mc_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [OP_W-1:0]    op_i6,
    input  logic [FUNCT_W-1:0] funct_i6,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_en_o,
    output logic [1:0]         pc_src_o2,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o2,
    output logic               apply_shift_o,
    output logic [1:0]         alu_alt_ctrl_o2,
    output logic               reg_dst_rtrd_o,
    output logic               mem_to_reg_o,
    output logic               enable_wreg_o,
    output logic               illegal_o
);

    state_t state_q;
    state_t state_n;
    state_t dec_state;
    logic   illegal_c;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= FETCH;
        else         state_q <= state_n;
    end

    // Next-state and illegal-opcode detection.
    always_comb begin
        state_n   = FETCH;
        illegal_c = 1'b0;
        case (state_q)
            FETCH:   state_n = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (op_i6)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = RTYPEEX;
                    OP_BEQ:       state_n = BEQEX;
                    OP_BNE:       state_n = BNEEX;
                    OP_ADDI:      state_n = ADDIEX;
                    OP_J:         state_n = JEX;
                    default: begin
                        state_n   = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (op_i6 == OP_LW)      state_n = MEMRD;
                else if (op_i6 == OP_SW) state_n = MEMWR;
                else                     state_n = FETCH;
            end
            MEMRD:   state_n = mem_ready_i ? MEMWB : MEMRD;
            MEMWB:   state_n = FETCH;
            MEMWR:   state_n = mem_ready_i ? FETCH : MEMWR;
            RTYPEEX: state_n = RTYPEWB;
            RTYPEWB: state_n = FETCH;
            BEQEX:   state_n = FETCH;
            BNEEX:   state_n = FETCH;
            ADDIEX:  state_n = ADDIWB;
            ADDIWB:  state_n = FETCH;
            JEX:     state_n = FETCH;
            default: state_n = FETCH;
        endcase
    end

    // In reset the selects show FETCH values; enables are masked below.
    assign dec_state = reset_i ? FETCH : state_q;

    mc_out_dec u_out_dec (
        .state     (dec_state),
        .funct     (funct_i6),
        .zero      (zero_i),
        .mem_ready (mem_ready_i),
        .ctrl      (ctrl_dec)
    );

    // Reset aborts any in-flight instruction: no memory, PC, IR or register writes.
    always_comb begin
        ctrl = ctrl_dec;
        if (reset_i) begin
            ctrl.mem_req     = 1'b0;
            ctrl.mem_write   = 1'b0;
            ctrl.ir_write    = 1'b0;
            ctrl.pc_en       = 1'b0;
            ctrl.enable_wreg = 1'b0;
        end
    end

    assign mem_req_o       = ctrl.mem_req;
    assign mem_write_o     = ctrl.mem_write;
    assign iord_o          = ctrl.iord;
    assign ir_write_o      = ctrl.ir_write;
    assign pc_en_o         = ctrl.pc_en;
    assign pc_src_o2       = ctrl.pc_src;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o2    = ctrl.alu_src_b;
    assign apply_shift_o   = ctrl.apply_shift;
    assign alu_alt_ctrl_o2 = ctrl.alu_alt_ctrl;
    assign reg_dst_rtrd_o  = ctrl.reg_dst_rtrd;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign enable_wreg_o   = ctrl.enable_wreg;
    assign illegal_o       = illegal_c & ~reset_i;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle.
module tb_mc_controller;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [5:0] op_i6;
    logic [5:0] funct_i6;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_write_o, iord_o, ir_write_o, pc_en_o;
    logic [1:0] pc_src_o2, alu_src_b_o2, alu_alt_ctrl_o2;
    logic       alu_src_a_o, apply_shift_o, reg_dst_rtrd_o, mem_to_reg_o;
    logic       enable_wreg_o, illegal_o;

    int checks = 0;
    int errors = 0;

    mc_controller dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .op_i6           (op_i6),
        .funct_i6        (funct_i6),
        .zero_i          (zero_i),
        .mem_ready_i     (mem_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_write_o     (mem_write_o),
        .iord_o          (iord_o),
        .ir_write_o      (ir_write_o),
        .pc_en_o         (pc_en_o),
        .pc_src_o2       (pc_src_o2),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o2    (alu_src_b_o2),
        .apply_shift_o   (apply_shift_o),
        .alu_alt_ctrl_o2 (alu_alt_ctrl_o2),
        .reg_dst_rtrd_o  (reg_dst_rtrd_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .enable_wreg_o   (enable_wreg_o),
        .illegal_o       (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // {req,wr,iord,irw,pcen,pcsrc[2],srca,srcb[2],shift,alt[2],regdst,m2r,wreg,illegal}
    wire [16:0] ctl = {mem_req_o, mem_write_o, iord_o, ir_write_o, pc_en_o, pc_src_o2,
                       alu_src_a_o, alu_src_b_o2, apply_shift_o, alu_alt_ctrl_o2,
                       reg_dst_rtrd_o, mem_to_reg_o, enable_wreg_o, illegal_o};

    localparam logic [16:0] V_RESET   = 17'b0_0_0_0_0_00_0_01_0_00_0_0_0_0;
    localparam logic [16:0] V_F_STALL = 17'b1_0_0_0_0_00_0_01_0_00_0_0_0_0;
    localparam logic [16:0] V_F_RDY   = 17'b1_0_0_1_1_00_0_01_0_00_0_0_0_0;
    localparam logic [16:0] V_DEC     = 17'b0_0_0_0_0_00_0_11_0_00_0_0_0_0;
    localparam logic [16:0] V_DEC_ILL = 17'b0_0_0_0_0_00_0_11_0_00_0_0_0_1;
    localparam logic [16:0] V_ADR_IMM = 17'b0_0_0_0_0_00_1_10_0_00_0_0_0_0;
    localparam logic [16:0] V_MEMRD   = 17'b1_0_1_0_0_00_0_00_0_00_0_0_0_0;
    localparam logic [16:0] V_MEMWB   = 17'b0_0_0_0_0_00_0_00_0_00_0_1_1_0;
    localparam logic [16:0] V_MEMWR   = 17'b1_1_1_0_0_00_0_00_0_00_0_0_0_0;
    localparam logic [16:0] V_REX_SH  = 17'b0_0_0_0_0_00_1_00_1_10_0_0_0_0;
    localparam logic [16:0] V_REX     = 17'b0_0_0_0_0_00_1_00_0_10_0_0_0_0;
    localparam logic [16:0] V_RWB     = 17'b0_0_0_0_0_00_0_00_0_00_1_0_1_0;
    localparam logic [16:0] V_BR_T    = 17'b0_0_0_0_1_01_1_00_0_01_0_0_0_0;
    localparam logic [16:0] V_BR_N    = 17'b0_0_0_0_0_01_1_00_0_01_0_0_0_0;
    localparam logic [16:0] V_ADDIWB  = 17'b0_0_0_0_0_00_0_00_0_00_0_0_1_0;
    localparam logic [16:0] V_JEX     = 17'b0_0_0_0_1_10_0_00_0_00_0_0_0_0;

    task automatic test_reset();
        reset_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        checks++;
        if (ctl !== V_RESET) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", ctl, V_RESET);
        end
        reset_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        checks++;
        if (ctl !== V_F_STALL) begin
            errors++;
            $display("FAIL reset_fetch: got %b expected %b", ctl, V_F_STALL);
        end
        @(negedge clk_i);
    endtask

    task automatic test_lw();
        logic [16:0] ev [5] = '{V_F_RDY, V_DEC, V_ADR_IMM, V_MEMRD, V_MEMWB};
        op_i6 = 6'h23; funct_i6 = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL lw[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_mem_stall();
        logic [16:0] ev [11] = '{V_F_RDY, V_DEC, V_ADR_IMM, V_MEMRD, V_MEMRD, V_MEMWB,
                                 V_F_RDY, V_DEC, V_ADR_IMM, V_MEMWR, V_MEMWR};
        logic        rv [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        funct_i6 = 6'h00; zero_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            op_i6 = (i < 6) ? 6'h23 : 6'h2B;
            mem_ready_i = rv[i];
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL mem_stall[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_fetch_stall();
        logic [16:0] ev [6] = '{V_F_STALL, V_F_STALL, V_F_STALL, V_F_RDY, V_DEC, V_JEX};
        logic        rv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        op_i6 = 6'h02; funct_i6 = 6'h00; zero_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready_i = rv[i];
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL fetch_stall_j[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic        zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [16:0] ex  [4] = '{V_BR_T, V_BR_N, V_BR_T, V_BR_N};
        logic [16:0] ev [3];
        funct_i6 = 6'h00; mem_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            op_i6 = ops[c]; zero_i = zs[c];
            ev = '{V_F_RDY, V_DEC, ex[c]};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (ctl !== ev[i]) begin
                    errors++;
                    $display("FAIL branch%0d[%0d]: got %b expected %b", c, i, ctl, ev[i]);
                end
                @(negedge clk_i);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [2] = '{6'h02, 6'h20};
        logic [16:0] ex [2] = '{V_REX_SH, V_REX};
        logic [16:0] ev [4];
        op_i6 = 6'h00; zero_i = 1'b0; mem_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            funct_i6 = fn[c];
            ev = '{V_F_RDY, V_DEC, ex[c], V_RWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++;
                if (ctl !== ev[i]) begin
                    errors++;
                    $display("FAIL rtype%0d[%0d]: got %b expected %b", c, i, ctl, ev[i]);
                end
                @(negedge clk_i);
            end
        end
    endtask

    task automatic test_addi();
        logic [16:0] ev [4] = '{V_F_RDY, V_DEC, V_ADR_IMM, V_ADDIWB};
        logic        rv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        op_i6 = 6'h08; funct_i6 = 6'h00; zero_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = rv[i];
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL addi[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] ev [3] = '{V_F_RDY, V_DEC_ILL, V_F_STALL};
        logic        rv [3] = '{1'b1, 1'b1, 1'b0};
        op_i6 = 6'h3F; funct_i6 = 6'h00; zero_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = rv[i];
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset_memwr();
        logic [16:0] ev [6] = '{V_F_RDY, V_DEC, V_ADR_IMM, V_MEMWR, V_RESET, V_F_STALL};
        logic        rv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        rs [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op_i6 = 6'h2B; funct_i6 = 6'h00; zero_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_ready_i = rv[i];
            reset_i = rs[i];
            #1;
            checks++;
            if (ctl !== ev[i]) begin
                errors++;
                $display("FAIL reset_memwr[%0d]: got %b expected %b", i, ctl, ev[i]);
            end
            @(negedge clk_i);
        end
    endtask

    initial begin
        reset_i = 1'b1; op_i6 = 6'h00; funct_i6 = 6'h00;
        zero_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        test_reset();
        test_lw();
        test_mem_stall();
        test_fetch_stall();
        test_branch();
        test_rtype();
        test_addi();
        test_illegal();
        test_reset_memwr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
